// File: rtl/imem_loader.sv
// rtl/imem_loader.sv - byte-stream boot loader that packs big-endian words into instruction memory
// Optional trailing XOR checksum byte: define IMEM_LOADER_CHECKSUM_EN.
module imem_loader #(
    parameter int ADDR_W = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        byte_valid,
    input  logic [7:0]  byte_data,
    output logic        byte_ready,
    output logic        mem_we,
    output logic [31:0] mem_adr,
    output logic [31:0] mem_wdata,
    output logic        cpu_hold,
    output logic        done,
    output logic        error
);
    localparam int DEPTH = 2 ** ADDR_W;

    typedef enum logic [2:0] {
        S_IDLE,
        S_HDR_HI,
        S_HDR_LO,
        S_DATA,
        S_WRITE,
`ifdef IMEM_LOADER_CHECKSUM_EN
        S_CHK,
`endif
        S_DONE,
        S_ERR
    } state_t;

`ifdef IMEM_LOADER_CHECKSUM_EN
    localparam state_t S_FIN = S_CHK;
`else
    localparam state_t S_FIN = S_DONE;
`endif

    state_t        state_q, state_d;
    logic [15:0]   n_q, n_d;
    logic [ADDR_W:0] cnt_q, cnt_d;
    logic [1:0]    bcnt_q, bcnt_d;
    logic [23:0]   word_q, word_d;
    logic          ready_q, ready_d;
    logic          we_q, we_d;
    logic [31:0]   adr_q, adr_d;
    logic [31:0]   wdata_q, wdata_d;
    logic          hold_q, hold_d;
    logic          done_q, done_d;
    logic          err_q, err_d;
    logic [15:0]   n_full;
    logic          fire;
`ifdef IMEM_LOADER_CHECKSUM_EN
    logic [7:0]    xor_q, xor_d;
`endif

    assign fire   = byte_valid & ready_q;
    assign n_full = {n_q[15:8], byte_data};

    always_comb begin
        state_d = state_q;
        n_d     = n_q;
        cnt_d   = cnt_q;
        bcnt_d  = bcnt_q;
        word_d  = word_q;
        adr_d   = adr_q;
        wdata_d = wdata_q;
`ifdef IMEM_LOADER_CHECKSUM_EN
        xor_d   = xor_q;
`endif
        case (state_q)
            S_IDLE, S_DONE, S_ERR: begin
                if (start) begin
                    state_d = S_HDR_HI;
                    cnt_d   = '0;
                    bcnt_d  = '0;
                    word_d  = '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
                    xor_d   = '0;
`endif
                end
            end
            S_HDR_HI: begin
                if (fire) begin
                    n_d[15:8] = byte_data;
                    state_d   = S_HDR_LO;
                end
            end
            S_HDR_LO: begin
                if (fire) begin
                    n_d[7:0] = byte_data;
                    if (n_full == 16'd0)
                        state_d = S_FIN;
                    else if ({16'd0, n_full} > 32'(DEPTH))
                        state_d = S_ERR;
                    else
                        state_d = S_DATA;
                end
            end
            S_DATA: begin
                if (fire) begin
                    word_d = {word_q[15:0], byte_data};
                    bcnt_d = bcnt_q + 2'd1;
`ifdef IMEM_LOADER_CHECKSUM_EN
                    xor_d  = xor_q ^ byte_data;
`endif
                    if (bcnt_q == 2'd3) begin
                        wdata_d = {word_q, byte_data};
                        adr_d   = 32'({cnt_q[ADDR_W-1:0], 2'b00});
                        state_d = S_WRITE;
                    end
                end
            end
            S_WRITE: begin
                cnt_d = cnt_q + 1'b1;
                if (32'(cnt_q) + 32'd1 == 32'(n_q))
                    state_d = S_FIN;
                else
                    state_d = S_DATA;
            end
`ifdef IMEM_LOADER_CHECKSUM_EN
            S_CHK: begin
                if (fire)
                    state_d = (byte_data == xor_q) ? S_DONE : S_ERR;
            end
`endif
            default: state_d = S_IDLE;
        endcase

        // Outputs are registered, so they are decoded from the upcoming state.
        ready_d = (state_d == S_HDR_HI) || (state_d == S_HDR_LO) || (state_d == S_DATA)
`ifdef IMEM_LOADER_CHECKSUM_EN
                  || (state_d == S_CHK)
`endif
                  ;
        we_d    = (state_d == S_WRITE);
        done_d  = (state_d == S_DONE);
        err_d   = (state_d == S_ERR);
        hold_d  = (state_d != S_DONE);
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= S_IDLE;
            n_q     <= '0;
            cnt_q   <= '0;
            bcnt_q  <= '0;
            word_q  <= '0;
            ready_q <= 1'b0;
            we_q    <= 1'b0;
            adr_q   <= '0;
            wdata_q <= '0;
            hold_q  <= 1'b1;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
`ifdef IMEM_LOADER_CHECKSUM_EN
            xor_q   <= '0;
`endif
        end else begin
            state_q <= state_d;
            n_q     <= n_d;
            cnt_q   <= cnt_d;
            bcnt_q  <= bcnt_d;
            word_q  <= word_d;
            ready_q <= ready_d;
            we_q    <= we_d;
            adr_q   <= adr_d;
            wdata_q <= wdata_d;
            hold_q  <= hold_d;
            done_q  <= done_d;
            err_q   <= err_d;
`ifdef IMEM_LOADER_CHECKSUM_EN
            xor_q   <= xor_d;
`endif
        end
    end

    assign byte_ready = ready_q;
    assign mem_we     = we_q;
    assign mem_adr    = adr_q;
    assign mem_wdata  = wdata_q;
    assign cpu_hold   = hold_q;
    assign done       = done_q;
    assign error      = err_q;

endmodule

// File: tb/tb_imem_loader.sv
// tb/tb_imem_loader.sv - self-checking bench for imem_loader
module tb_imem_loader;
    localparam int ADDR_W = 8;
    localparam int DEPTH  = 2 ** ADDR_W;
`ifdef IMEM_LOADER_CHECKSUM_EN
    localparam bit CHK_EN = 1'b1;
`else
    localparam bit CHK_EN = 1'b0;
`endif

    typedef logic [7:0]  bq_t[$];
    typedef logic [31:0] wq_t[$];

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start = 1'b0;
    logic        byte_valid = 1'b0;
    logic [7:0]  byte_data = 8'h00;
    logic        byte_ready, mem_we, cpu_hold, done, error;
    logic [31:0] mem_adr, mem_wdata;

    int errors = 0;
    int checks = 0;

    logic [31:0] wr_adr[$];
    logic [31:0] wr_dat[$];

    imem_loader #(.ADDR_W(ADDR_W)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .byte_valid (byte_valid),
        .byte_data  (byte_data),
        .byte_ready (byte_ready),
        .mem_we     (mem_we),
        .mem_adr    (mem_adr),
        .mem_wdata  (mem_wdata),
        .cpu_hold   (cpu_hold),
        .done       (done),
        .error      (error)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (mem_we === 1'b1) begin
            wr_adr.push_back(mem_adr);
            wr_dat.push_back(mem_wdata);
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_ready"}, 32'(byte_ready), 32'd0);
        check({tag, "_we"},    32'(mem_we),     32'd0);
        check({tag, "_adr"},   mem_adr,         32'd0);
        check({tag, "_wdata"}, mem_wdata,       32'd0);
        check({tag, "_done"},  32'(done),       32'd0);
        check({tag, "_error"}, 32'(error),      32'd0);
        check({tag, "_hold"},  32'(cpu_hold),   32'd1);
    endtask

    task automatic do_start();
        wr_adr.delete();
        wr_dat.delete();
        start = 1'b1;
        tick();
        start = 1'b0;
        check("start_ready", 32'(byte_ready), 32'd1);
        check("start_done",  32'(done),       32'd0);
        check("start_error", 32'(error),      32'd0);
        check("start_hold",  32'(cpu_hold),   32'd1);
    endtask

    // mode 0: always valid, 1: valid every other cycle, 2: random valid plus stray start pulses
    task automatic send(input bq_t b, input int mode);
        int idx = 0;
        int guard = 0;
        while (idx < b.size() && guard < 20000) begin
            case (mode)
                0:       byte_valid = 1'b1;
                1:       byte_valid = (guard % 2 == 0);
                default: byte_valid = 1'($urandom_range(0, 1));
            endcase
            start     = (mode == 2) ? ($urandom_range(0, 7) == 0) : 1'b0;
            byte_data = byte_valid ? b[idx] : 8'($urandom);
            check("ready_only_outside_write", 32'(byte_ready), 32'(!mem_we));
            if (byte_valid && byte_ready) idx++;
            tick();
            guard++;
        end
        byte_valid = 1'b0;
        start      = 1'b0;
        check("send_all_bytes_accepted", 32'(idx), 32'(b.size()));
    endtask

    function automatic bq_t build_stream(input wq_t words, input bit bad_chk);
        bq_t s;
        logic [15:0] nn;
        logic [7:0]  x;
        logic [31:0] w;
        nn = 16'(words.size());
        x  = 8'h00;
        s.push_back(nn[15:8]);
        s.push_back(nn[7:0]);
        foreach (words[i]) begin
            w = words[i];
            for (int k = 3; k >= 0; k--) begin
                s.push_back(w[k*8 +: 8]);
                x = x ^ w[k*8 +: 8];
            end
        end
        if (CHK_EN) s.push_back(bad_chk ? ~x : x);
        return s;
    endfunction

    task automatic load(input wq_t words, input int mode, input bit bad_chk);
        bq_t s;
        bit  ok;
        int  n;
        n  = words.size();
        s  = build_stream(words, bad_chk);
        ok = !(CHK_EN && bad_chk);
        do_start();
        send(s, mode);
        if (!(CHK_EN || n == 0)) begin
            check("final_write_cycle_we",   32'(mem_we), 32'd1);
            check("final_write_cycle_done", 32'(done),   32'd0);
            tick();
        end
        check("end_done",  32'(done),       32'(ok));
        check("end_error", 32'(error),      32'(!ok));
        check("end_hold",  32'(cpu_hold),   32'(!ok));
        check("end_ready", 32'(byte_ready), 32'd0);
        check("write_count", 32'(wr_adr.size()), 32'(n));
        for (int i = 0; i < n && i < wr_adr.size(); i++) begin
            check("write_adr",  wr_adr[i], 32'(i * 4));
            check("write_data", wr_dat[i], words[i]);
        end
    endtask

    function automatic wq_t rand_words(input int n);
        wq_t w;
        for (int i = 0; i < n; i++) w.push_back($urandom);
        return w;
    endfunction

    initial begin
        wq_t w;
        bq_t s;

        // Reset
        rst = 1'b0;
        tick(); tick(); tick();
        check_reset_outputs("reset");
        rst = 1'b1;
        tick();
        check_reset_outputs("idle");

        // Directed two-word image
        w = '{32'h20080005, 32'hAC010004};
        load(w, 0, 1'b0);

        // Empty image
        w.delete();
        load(w, 0, 1'b0);

        // N = DEPTH+1 rejected after the header
        do_start();
        s = '{8'h01, 8'h01};
        send(s, 0);
        check("oversize_error", 32'(error),      32'd1);
        check("oversize_done",  32'(done),       32'd0);
        check("oversize_hold",  32'(cpu_hold),   32'd1);
        check("oversize_ready", 32'(byte_ready), 32'd0);
        tick(); tick();
        check("oversize_writes", 32'(wr_adr.size()), 32'd0);

        // Three words with valid toggled every other cycle
        load(rand_words(3), 1, 1'b0);

        // Reset in the middle of a word aborts the load
        do_start();
        s = '{8'h00, 8'h01, 8'hAA, 8'hBB};
        send(s, 0);
        rst = 1'b0;
        tick();
        check_reset_outputs("midload_reset");
        rst = 1'b1;
        tick();
        check("midload_writes", 32'(wr_adr.size()), 32'd0);
        load(rand_words(1), 0, 1'b0);

        // Checksum mismatch then recovery (only meaningful with the checksum built in)
        if (CHK_EN) begin
            load(rand_words(2), 0, 1'b1);
            load(rand_words(2), 2, 1'b0);
        end

        // Random images with random stalls and ignored start pulses
        for (int t = 0; t < 6; t++) load(rand_words($urandom_range(1, 6)), 2, 1'b0);

        // Full-capacity image
        load(rand_words(DEPTH), 0, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
